// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with zero-wait writes, one-wait classic reads and
// pipelined incrementing bursts (linear or wrap-4/8/16), with range-error reporting.
module wb_bram_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cyc,
  input  logic                      stb,
  input  logic                      we,
  input  logic [31:0]               adr,
  input  logic [DATA_WIDTH/8-1:0]   sel,
  input  logic [2:0]                cti,
  input  logic [1:0]                bte,
  input  logic [DATA_WIDTH-1:0]     dat_ms,
  output logic [DATA_WIDTH-1:0]     dat_sm,
  output logic                      ack,
  output logic                      err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [AW-1:0]           nxt_q, nxt_d;
  logic [DATA_WIDTH-1:0]   dat_sm_q, dat_sm_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    req, oor, wr_hit;
  logic [AW-1:0]           idx, rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_adr;

  assign req        = cyc & stb;
  assign idx        = adr[AW+OFF-1:OFF];
  assign oor        = {1'b0, idx} >= (AW+1)'(DEPTH);
  assign unused_adr = ^adr;
  assign dat_sm     = dat_sm_q;

  // Wrap modes only advance the low log2(N) bits; linear wraps at DEPTH.
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] x, input logic [1:0] b);
    logic [AW-1:0] m, p;
    p = x + AW'(1);
    case (b)
      2'b01:   m = AW'(3);
      2'b10:   m = AW'(7);
      2'b11:   m = AW'(15);
      default: m = '0;
    endcase
    if (b == 2'b00) return ({1'b0, x} == (AW+1)'(DEPTH - 1)) ? '0 : p;
    return (x & ~m) | (p & m);
  endfunction

  // A wrap burst near the top of a non power-of-two memory can step past DEPTH.
  always_comb begin
    rd_addr = (state_q == BURST) ? nxt_q : idx;
    rd_data = '0;
    if ({1'b0, rd_addr} < (AW+1)'(DEPTH)) rd_data = mem[rd_addr];
  end

  assign wr_hit = (state_q == IDLE) & req & we & ~oor;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wr_hit && sel[i]) mem[idx][8*i +: 8] <= dat_ms[8*i +: 8];
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    nxt_d    = nxt_q;
    dat_sm_d = dat_sm_q;
    ack      = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (oor) begin
            err = 1'b1;
          end else if (we) begin
            ack = 1'b1;
          end else begin
            dat_sm_d = rd_data;
            ack_d    = 1'b1;
            if (cti == 3'b010) begin
              nxt_d   = inc(idx, bte);
              state_d = BURST;
            end else begin
              state_d = CLASSIC;
            end
          end
        end
      end
      CLASSIC: begin
        ack     = ack_q & req;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      BURST: begin
        ack = ack_q & req;
        if (ack) begin
          if (cti == 3'b111) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end else begin
            dat_sm_d = rd_data;
            nxt_d    = inc(nxt_q, bte);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cyc) begin
      ack_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      nxt_q    <= '0;
      dat_sm_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      nxt_q    <= nxt_d;
      dat_sm_q <= dat_sm_d;
    end
  end
endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench: an 8-word instance for burst/byte-lane cases and a 1000-word
// instance for range errors, both on one shared Wishbone master bus.
module tb_wb_bram_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_ms = '0;
  logic [31:0] dat8, dat1k;
  logic        ack8, err8, ack1k, err1k;
  logic [31:0] ev [4];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  wb_bram_burst #(.DATA_WIDTH(32), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .cti(cti), .bte(bte), .dat_ms(dat_ms), .dat_sm(dat8), .ack(ack8), .err(err8));

  wb_bram_burst #(.DATA_WIDTH(32), .DEPTH(1000)) u_dut1k (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .cti(cti), .bte(bte), .dat_ms(dat_ms), .dat_sm(dat1k), .ack(ack1k), .err(err1k));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; sel = '0;
  endtask

  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'(w) << 2; sel = s; dat_ms = d; cti = 3'b000;
    @(negedge clk);
    tick();
    idle_bus();
  endtask

  task automatic rd(input int w, input logic [31:0] exp, input bit big, input string tag);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'(w) << 2; cti = 3'b000;
    @(negedge clk);
    chk({tag, "_wait"}, big ? ack1k : ack8, 1'b0);
    tick();
    @(negedge clk);
    chk({tag, "_ack"}, big ? ack1k : ack8, 1'b1);
    chk({tag, "_dat"}, big ? dat1k : dat8, exp);
    tick();
    idle_bus();
    @(negedge clk);
    chk({tag, "_ack_off"}, big ? ack1k : ack8, 1'b0);
  endtask

  // Four-beat burst on the 8-word instance; expected data in ev[].
  task automatic burst(input int start, input logic [1:0] b, input int stall_at, input string tag);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'(start) << 2; cti = 3'b010; bte = b;
    @(negedge clk);
    chk({tag, "_wait"}, ack8, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        stb = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk($sformatf("%s_stall_ack", tag), ack8, 1'b0);
          tick();
        end
        stb = 1'b1;
      end
      if (k == 3) cti = 3'b111;
      @(negedge clk);
      chk($sformatf("%s_b%0d_ack", tag, k), ack8, 1'b1);
      chk($sformatf("%s_b%0d_dat", tag, k), dat8, ev[k]);
      tick();
    end
    idle_bus();
    @(negedge clk);
    chk({tag, "_end_ack"}, ack8, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_ack8", ack8, 1'b0);
    chk("rst_err8", err8, 1'b0);
    chk("rst_dat8", dat8, 32'h0);
    chk("rst_dat1k", dat1k, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // byte-lane write: first write checks zero-wait combinational ack
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd3 << 2; sel = 4'b1111; dat_ms = 32'hA5A5A5A5;
    @(negedge clk);
    chk("wr_ack", ack8, 1'b1);
    chk("wr_err", err8, 1'b0);
    tick();
    idle_bus();
    wr(3, 32'h000000FF, 4'b0001);
    rd(3, 32'hA5A5A5FF, 1'b0, "lane");

    for (int k = 0; k < 8; k++) wr(k, 32'(k * 32'h11), 4'hF);

    ev[0] = 32'h55; ev[1] = 32'h66; ev[2] = 32'h77; ev[3] = 32'h00;
    burst(5, 2'b00, -1, "lin");
    ev[0] = 32'h66; ev[1] = 32'h77; ev[2] = 32'h44; ev[3] = 32'h55;
    burst(6, 2'b01, -1, "wrap4");
    ev[0] = 32'h11; ev[1] = 32'h22; ev[2] = 32'h33; ev[3] = 32'h44;
    burst(1, 2'b00, 2, "stall");

    // reset in the middle of beat 2
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0; cti = 3'b010; bte = 2'b00;
    tick();
    @(negedge clk);
    chk("mid_b0_ack", ack8, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack8, 1'b0);
    chk("mid_rst_dat", dat8, 32'h0);
    idle_bus();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", ack8, 1'b0);
    rd(3, 32'h33, 1'b0, "post_rst");

    // out-of-range on the 1000-word instance
    wr(999, 32'h00000999, 4'hF);
    wr(488, 32'h00000488, 4'hF);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd1000 << 2; sel = 4'hF; dat_ms = 32'hDEADBEEF;
    @(negedge clk);
    chk("oor_wr_err", err1k, 1'b1);
    chk("oor_wr_ack", ack1k, 1'b0);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("oor_rd_err", err1k, 1'b1);
    chk("oor_rd_ack", ack1k, 1'b0);
    tick();
    idle_bus();
    @(negedge clk);
    chk("oor_idle_err", err1k, 1'b0);
    rd(999, 32'h00000999, 1'b1, "oor_w999");
    rd(488, 32'h00000488, 1'b1, "oor_w488");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
